bg_ram_scheduler: RTL and testbench
===================================

Name: bg_ram_scheduler

Overview:
- Sits in front of the background tile RAM (5-bit tile IDs, 19-bit address, 1-cycle registered read, independent write and read ports).
- Shares the single read port between the pixel renderer (render) and the game-logic collision lookup (coll).
- Sequences the write port between a level loader (single writes) and a built-in clear/fill engine.
- Resolves same-cycle read/write hazards so every reader always sees the newest data.

Parameters:
- ADDR_W, 19, address width of the tile RAM
- DATA_W, 5, tile word width
- MEM_DEPTH, 6145, number of valid words (addresses 0..MEM_DEPTH-1)
- STARVE_LIMIT, 8, consecutive coll denials before the guard forces a grant (guard build only)

Ports:
- Clk  in  1  system clock; all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- render_req  in  1  renderer read request this cycle
- render_addr  in  ADDR_W  renderer read address
- render_valid  out  1  render_data valid (one cycle after grant)
- render_data  out  DATA_W  tile returned to renderer
- render_stall  out  1  render request denied this cycle (guard build only; else 0)
- coll_req  in  1  collision read request; held until coll_gnt
- coll_addr  in  ADDR_W  collision read address
- coll_gnt  out  1  coll request accepted this cycle
- coll_valid  out  1  coll_data valid (one cycle after coll_gnt)
- coll_data  out  DATA_W  tile returned to collision logic
- wr_req  in  1  loader write request
- wr_addr  in  ADDR_W  loader write address
- wr_data  in  DATA_W  loader write data
- wr_ready  out  1  loader write accepted when wr_req and wr_ready are both high
- clr_start  in  1  one-cycle pulse starting a fill
- clr_base  in  ADDR_W  first fill address
- clr_len  in  ADDR_W  number of words to fill (0 = no-op)
- clr_value  in  DATA_W  fill value
- clr_busy  out  1  fill engine active
- clr_done  out  1  one-cycle pulse when a fill completes
- oob_err  out  1  sticky: an out-of-range access occurred; cleared only by reset
- ram_we  out  1  to RAM we
- ram_write_address  out  ADDR_W  to RAM write_address
- ram_data_In  out  DATA_W  to RAM data_In
- ram_read_address  out  ADDR_W  to RAM read_address
- ram_data_Out  in  DATA_W  from RAM data_Out

Behaviour:
- Reset: all registered outputs 0 (render_valid, coll_gnt, coll_valid, clr_busy, clr_done, oob_err, ram_we, render_stall); data outputs 0. Fill FSM returns to IDLE. Reset during a fill abandons it with no clr_done.
- Read arbitration: combinational, fixed priority render > coll.
  - ram_read_address = render_addr if render_req, else coll_addr if coll_req, else hold the last value.
  - coll_gnt is high only when coll_req is high and render_req is low.
- Read latency: a grant in cycle N gives valid plus data in cycle N+1. The owner tag is registered at N. Back-to-back grants every cycle are supported.
- Out-of-range read (addr >= MEM_DEPTH): still granted; data returned as 0 with valid; sets oob_err.
- Write port mux: the fill engine has priority. wr_ready = !clr_busy && !clr_start.
  - Accepted loader write drives ram_we=1 with wr_addr/wr_data in the same cycle.
  - An out-of-range write is accepted but ram_we=0, and oob_err is set.
- Hazard bypass: if ram_we=1 and the write address equals the granted read address in cycle N, the returned data in N+1 is the new write data, not ram_data_Out.
- Fill FSM, IDLE -> FILL -> DONE -> IDLE:
  - IDLE: on clr_start with clr_len != 0, latch base, len and value, then go to FILL. With clr_len = 0, pulse clr_done next cycle and stay in IDLE.
  - FILL: one write per cycle at base+i, i = 0..len-1, with clr_busy=1.
  - Addresses >= MEM_DEPTH are clipped: the fill terminates early at MEM_DEPTH-1 and sets oob_err.
  - DONE: clr_done=1 for one cycle, then IDLE.
  - clr_start while busy is ignored.
- Width rules: address arithmetic is computed at ADDR_W+1 bits to detect overflow; no wrap-around.

Optional Feature:
- Macro: BGSCHED_STARVE_GUARD_EN.
- Enabled:
  - A counter increments each cycle coll_req is high but not granted, and resets on coll_gnt.
  - When it reaches STARVE_LIMIT, coll wins the next cycle even over render. render_stall=1 that cycle and no render_valid follows.
- Disabled: strict priority, coll may starve, render_stall tied 0.

Test Plan:
- Reset with Reset_n=0 mid-fill (len=100 at i=40) -> all outputs 0 immediately; clr_busy=0; no clr_done after release.
- render_req addr 0x10 at cycle N with RAM[0x10]=5 -> render_valid=1 and render_data=5 at N+1; simultaneous coll_req gets coll_gnt=0.
- wr_req addr 0x20 data 7, same cycle render read 0x20 holding old 3 -> render_data=7 at N+1 (bypass).
- clr_start base 6140 len 10 value 0 -> writes 6140..6144 over 5 cycles, clr_done pulse, oob_err=1, wr_ready=0 throughout the fill.
- render_req continuously plus coll_req, guard build with STARVE_LIMIT=8 -> coll_gnt and render_stall on the 9th cycle; non-guard build -> coll_gnt never asserts.
- render read addr 7000 -> render_valid=1, render_data=0, oob_err=1.

Source files
------------

// File: rtl/bg_ram_scheduler.sv
// rtl/bg_ram_scheduler.sv - background tile RAM read arbiter, write mux and fill engine
// Optional coll starvation guard: define BGSCHED_STARVE_GUARD_EN.
module bg_ram_scheduler #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 5,
  parameter int MEM_DEPTH    = 6145,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              render_req,
  input  logic [ADDR_W-1:0] render_addr,
  output logic              render_valid,
  output logic [DATA_W-1:0] render_data,
  output logic              render_stall,
  input  logic              coll_req,
  input  logic [ADDR_W-1:0] coll_addr,
  output logic              coll_gnt,
  output logic              coll_valid,
  output logic [DATA_W-1:0] coll_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clr_start,
  input  logic [ADDR_W-1:0] clr_base,
  input  logic [ADDR_W-1:0] clr_len,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              oob_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_write_address,
  output logic [DATA_W-1:0] ram_data_In,
  output logic [ADDR_W-1:0] ram_read_address,
  input  logic [DATA_W-1:0] ram_data_Out
);
  localparam int XW = ADDR_W + 1;
  localparam logic [XW-1:0] DEPTH_X = XW'(MEM_DEPTH);
  localparam logic [XW-1:0] LAST_X  = XW'(MEM_DEPTH - 1);

  if (STARVE_LIMIT < 1 || MEM_DEPTH > (1 << ADDR_W)) begin : g_param_check
    $error("bg_ram_scheduler: bad parameters");
  end

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} fill_state_e;

  fill_state_e       state_q;
  logic [XW-1:0]     fill_addr_q, fill_end_q, end_x;
  logic [DATA_W-1:0] fill_val_q;
  logic              clr_busy_q, clr_done_q;

  logic              force_coll, render_gnt, coll_gnt_w, any_gnt;
  logic [ADDR_W-1:0] rd_addr_d, rd_addr_q;
  logic              rd_oob, wr_oob, fill_oob, wr_accept, bypass_d;
  logic              render_valid_q, coll_valid_q, rd_oob_q, byp_q, oob_q;
  logic [DATA_W-1:0] byp_data_q, ret_data;

`ifdef BGSCHED_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_d, starve_q;

  assign force_coll   = (starve_q >= SW'(STARVE_LIMIT));
  assign render_stall = force_coll && render_req;

  always_comb begin
    starve_d = starve_q;
    if (coll_gnt_w)
      starve_d = '0;
    else if (coll_req)
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) starve_q <= '0;
    else          starve_q <= starve_d;
  end
`else
  assign force_coll   = 1'b0;
  assign render_stall = 1'b0;
`endif

  assign render_gnt = render_req && !force_coll;
  assign coll_gnt_w = coll_req && (!render_req || force_coll);
  assign any_gnt    = render_gnt || coll_gnt_w;
  assign coll_gnt   = coll_gnt_w;

  // With no grant the read port keeps its previous address.
  always_comb begin
    rd_addr_d = rd_addr_q;
    if (render_gnt)
      rd_addr_d = render_addr;
    else if (coll_gnt_w)
      rd_addr_d = coll_addr;
  end
  assign ram_read_address = rd_addr_d;
  assign rd_oob = any_gnt && ({1'b0, rd_addr_d} >= DEPTH_X);

  assign wr_ready  = !clr_busy_q && !clr_start;
  assign wr_accept = wr_req && wr_ready;
  assign wr_oob    = wr_accept && ({1'b0, wr_addr} >= DEPTH_X);

  always_comb begin
    ram_we            = 1'b0;
    ram_write_address = wr_addr;
    ram_data_In       = wr_data;
    if (state_q == S_FILL) begin
      ram_we            = 1'b1;
      ram_write_address = fill_addr_q[ADDR_W-1:0];
      ram_data_In       = fill_val_q;
    end else if (wr_accept && !wr_oob) begin
      ram_we = 1'b1;
    end
  end

  // RAM reads return pre-write contents, so a same-cycle write to the read address is forwarded.
  assign bypass_d = any_gnt && ram_we && (ram_write_address == rd_addr_d);
  assign ret_data = rd_oob_q ? '0 : (byp_q ? byp_data_q : ram_data_Out);

  assign render_valid = render_valid_q;
  assign coll_valid   = coll_valid_q;
  assign render_data  = render_valid_q ? ret_data : '0;
  assign coll_data    = coll_valid_q ? ret_data : '0;
  assign oob_err      = oob_q;
  assign clr_busy     = clr_busy_q;
  assign clr_done     = clr_done_q;

  assign end_x    = {1'b0, clr_base} + {1'b0, clr_len} - XW'(1);
  assign fill_oob = (state_q == S_IDLE) && clr_start && (clr_len != '0) && (end_x >= DEPTH_X);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_addr_q      <= '0;
      render_valid_q <= 1'b0;
      coll_valid_q   <= 1'b0;
      rd_oob_q       <= 1'b0;
      byp_q          <= 1'b0;
      byp_data_q     <= '0;
      oob_q          <= 1'b0;
    end else begin
      rd_addr_q      <= rd_addr_d;
      render_valid_q <= render_gnt;
      coll_valid_q   <= coll_gnt_w;
      rd_oob_q       <= rd_oob;
      byp_q          <= bypass_d;
      byp_data_q     <= ram_data_In;
      oob_q          <= oob_q | rd_oob | wr_oob | fill_oob;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      fill_addr_q <= '0;
      fill_end_q  <= '0;
      fill_val_q  <= '0;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (clr_start) begin
            if (clr_len == '0) begin
              clr_done_q <= 1'b1;
            end else if ({1'b0, clr_base} >= DEPTH_X) begin
              state_q    <= S_DONE;
              clr_done_q <= 1'b1;
            end else begin
              state_q     <= S_FILL;
              clr_busy_q  <= 1'b1;
              fill_addr_q <= {1'b0, clr_base};
              fill_val_q  <= clr_value;
              fill_end_q  <= (end_x >= DEPTH_X) ? LAST_X : end_x;
            end
          end
        end
        S_FILL: begin
          if (fill_addr_q == fill_end_q) begin
            state_q    <= S_DONE;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
          end else begin
            fill_addr_q <= fill_addr_q + XW'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bg_ram_scheduler.sv
// tb/tb_bg_ram_scheduler.sv - self-checking bench for bg_ram_scheduler
module tb_bg_ram_scheduler;
  localparam int AW = 19;
  localparam int DW = 5;
  localparam int DEPTH = 6145;
  localparam int LIMIT = 8;
`ifdef BGSCHED_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset_n;
  logic render_req, render_valid, render_stall;
  logic [AW-1:0] render_addr;
  logic [DW-1:0] render_data;
  logic coll_req, coll_gnt, coll_valid;
  logic [AW-1:0] coll_addr;
  logic [DW-1:0] coll_data;
  logic wr_req, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic clr_start, clr_busy, clr_done, oob_err;
  logic [AW-1:0] clr_base, clr_len;
  logic [DW-1:0] clr_value;
  logic ram_we;
  logic [AW-1:0] ram_write_address, ram_read_address;
  logic [DW-1:0] ram_data_In, ram_data_Out;

  always #5 Clk = ~Clk;

  bg_ram_scheduler dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .render_req(render_req), .render_addr(render_addr), .render_valid(render_valid),
    .render_data(render_data), .render_stall(render_stall),
    .coll_req(coll_req), .coll_addr(coll_addr), .coll_gnt(coll_gnt),
    .coll_valid(coll_valid), .coll_data(coll_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_start(clr_start), .clr_base(clr_base), .clr_len(clr_len), .clr_value(clr_value),
    .clr_busy(clr_busy), .clr_done(clr_done), .oob_err(oob_err),
    .ram_we(ram_we), .ram_write_address(ram_write_address), .ram_data_In(ram_data_In),
    .ram_read_address(ram_read_address), .ram_data_Out(ram_data_Out)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 16) return 5'd5;
    if (a == 32) return 5'd3;
    return 5'((a + 1) % 32);
  endfunction

  // Tile RAM: registered read returning pre-write contents; out-of-range reads give 0x1F.
  logic [DW-1:0] mem [0:DEPTH-1];
  logic do_preload = 1'b0;
  always @(posedge Clk) begin
    if (do_preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
    end else if (ram_we && int'(ram_write_address) < DEPTH) begin
      mem[ram_write_address] <= ram_data_In;
    end
    ram_data_Out <= (int'(ram_read_address) < DEPTH) ? mem[ram_read_address] : 5'h1F;
  end

  int n_cmp = 0;
  int n_fail = 0;
  logic [DW-1:0] ref_mem [0:DEPTH-1];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    render_req = 1'b0; render_addr = '0; coll_req = 1'b0; coll_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    clr_start = 1'b0; clr_base = '0; clr_len = '0; clr_value = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge Clk); Reset_n = 1'b0;
    @(negedge Clk); Reset_n = 1'b1;
  endtask

  task automatic preload();
    @(negedge Clk); do_preload = 1'b1;
    @(negedge Clk); do_preload = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rv"}, int'(render_valid), 0);
    chk({tag, "_cv"}, int'(coll_valid), 0);
    chk({tag, "_cgnt"}, int'(coll_gnt), 0);
    chk({tag, "_busy"}, int'(clr_busy), 0);
    chk({tag, "_done"}, int'(clr_done), 0);
    chk({tag, "_oob"}, int'(oob_err), 0);
    chk({tag, "_we"}, int'(ram_we), 0);
    chk({tag, "_stall"}, int'(render_stall), 0);
    chk({tag, "_rdata"}, int'(render_data), 0);
    chk({tag, "_cdata"}, int'(coll_data), 0);
  endtask

  typedef struct {
    logic rr; logic [AW-1:0] ra; logic cr; logic [AW-1:0] ca;
    logic wr; logic [AW-1:0] wa; logic [DW-1:0] wd;
    logic e_cg; logic e_rv; logic [DW-1:0] e_rd; logic e_cv; logic [DW-1:0] e_cd; logic e_oob;
  } vec_t;

  function automatic vec_t mk(input logic rr, input logic [AW-1:0] ra, input logic cr,
                              input logic [AW-1:0] ca, input logic wr, input logic [AW-1:0] wa,
                              input logic [DW-1:0] wd, input logic e_cg, input logic e_rv,
                              input logic [DW-1:0] e_rd, input logic e_cv,
                              input logic [DW-1:0] e_cd, input logic e_oob);
    vec_t v;
    v.rr = rr; v.ra = ra; v.cr = cr; v.ca = ca; v.wr = wr; v.wa = wa; v.wd = wd;
    v.e_cg = e_cg; v.e_rv = e_rv; v.e_rd = e_rd; v.e_cv = e_cv; v.e_cd = e_cd; v.e_oob = e_oob;
    return v;
  endfunction

  vec_t vt [9];

  task automatic check_row(input int j);
    chk("tbl_rv", int'(render_valid), int'(vt[j].e_rv));
    if (vt[j].e_rv) chk("tbl_rdata", int'(render_data), int'(vt[j].e_rd));
    chk("tbl_cv", int'(coll_valid), int'(vt[j].e_cv));
    if (vt[j].e_cv) chk("tbl_cdata", int'(coll_data), int'(vt[j].e_cd));
    chk("tbl_oob", int'(oob_err), int'(vt[j].e_oob));
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 15) == 0) return 19'(6140 + $urandom_range(0, 8));
    return 19'($urandom_range(0, 31));
  endfunction

  initial begin
    int nw, nd, cnt, ra, wa;
    logic got, prev_rg, exp_g, have, pend, exp_oob, force_c, g_r, g_c, e_rv, e_cv;
    logic [DW-1:0] d, e_d;

    vt[0] = mk(1'b1, 19'h10, 1'b1, 19'h05, 1'b0, 19'h0, 5'h0,  1'b0, 1'b1, 5'd5,  1'b0, 5'd0,  1'b0);
    vt[1] = mk(1'b0, 19'h0,  1'b1, 19'h05, 1'b0, 19'h0, 5'h0,  1'b1, 1'b0, 5'd0,  1'b1, 5'd6,  1'b0);
    vt[2] = mk(1'b1, 19'h20, 1'b0, 19'h0,  1'b1, 19'h20, 5'd7, 1'b0, 1'b1, 5'd7,  1'b0, 5'd0,  1'b0);
    vt[3] = mk(1'b1, 19'h20, 1'b0, 19'h0,  1'b0, 19'h0, 5'h0,  1'b0, 1'b1, 5'd7,  1'b0, 5'd0,  1'b0);
    vt[4] = mk(1'b0, 19'h0,  1'b1, 19'h0C, 1'b1, 19'h0C, 5'h1F, 1'b1, 1'b0, 5'd0, 1'b1, 5'h1F, 1'b0);
    vt[5] = mk(1'b1, 19'h0C, 1'b1, 19'h02, 1'b0, 19'h0, 5'h0,  1'b0, 1'b1, 5'h1F, 1'b0, 5'd0,  1'b0);
    vt[6] = mk(1'b0, 19'h0,  1'b0, 19'h0,  1'b0, 19'h0, 5'h0,  1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0);
    vt[7] = mk(1'b0, 19'h0,  1'b1, 19'd6144, 1'b0, 19'h0, 5'h0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd1,  1'b0);
    vt[8] = mk(1'b1, 19'd7000, 1'b0, 19'h0, 1'b0, 19'h0, 5'h0, 1'b0, 1'b1, 5'd0,  1'b0, 5'd0,  1'b1);

    Reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge Clk);
    #1 chk_all_zero("rst");
    preload();
    @(negedge Clk); Reset_n = 1'b1;
    @(negedge Clk);
    chk_all_zero("post_rst");

    // Reset in the middle of a 100-word fill after 40 writes.
    clr_start = 1'b1; clr_base = 19'd100; clr_len = 19'd100; clr_value = 5'd9;
    @(negedge Clk); clr_start = 1'b0;
    #1 chk("mid_busy", int'(clr_busy), 1);
    chk("mid_wr_ready", int'(wr_ready), 0);
    repeat (40) @(negedge Clk);
    #1 chk("mid_addr", int'(ram_write_address), 140);
    #1 Reset_n = 1'b0;
    #1 chk_all_zero("mid_rst");
    @(negedge Clk); Reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      chk("mid_no_done", int'(clr_done), 0);
      chk("mid_no_busy", int'(clr_busy), 0);
    end
    chk("mid_mem100", int'(mem[100]), 9);
    chk("mid_mem139", int'(mem[139]), 9);
    chk("mid_mem140", int'(mem[140]), int'(init_val(140)));

    // Table-driven read/write/bypass/out-of-range vectors.
    for (int i = 0; i < 9; i++) begin
      @(negedge Clk);
      if (i > 0) check_row(i - 1);
      render_req = vt[i].rr; render_addr = vt[i].ra; coll_req = vt[i].cr; coll_addr = vt[i].ca;
      wr_req = vt[i].wr; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      #1 chk("tbl_cgnt", int'(coll_gnt), int'(vt[i].e_cg));
      chk("tbl_wr_ready", int'(wr_ready), 1);
    end
    @(negedge Clk);
    check_row(8);
    idle_inputs();

    // Fill clipped at the top of memory.
    do_reset();
    chk("fill_oob_pre", int'(oob_err), 0);
    @(negedge Clk);
    clr_start = 1'b1; clr_base = 19'd6140; clr_len = 19'd10; clr_value = 5'd0;
    wr_req = 1'b1; wr_addr = 19'h40; wr_data = 5'h11;
    #1 chk("fill_wr_ready_start", int'(wr_ready), 0);
    nw = 0; nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk); clr_start = 1'b0;
      #1;
      if (clr_busy) begin
        chk("fill_we", int'(ram_we), 1);
        chk("fill_addr", int'(ram_write_address), 6140 + nw);
        chk("fill_wr_ready", int'(wr_ready), 0);
        nw++;
      end
      if (clr_done) nd++;
    end
    wr_req = 1'b0;
    chk("fill_writes", nw, 5);
    chk("fill_done_pulses", nd, 1);
    chk("fill_oob", int'(oob_err), 1);
    chk("fill_mem6140", int'(mem[6140]), 0);
    chk("fill_mem6144", int'(mem[6144]), 0);

    // Zero-length fill: done pulse next cycle, never busy.
    @(negedge Clk); clr_start = 1'b1; clr_len = 19'd0;
    @(negedge Clk); clr_start = 1'b0;
    chk("len0_done", int'(clr_done), 1);
    chk("len0_busy", int'(clr_busy), 0);
    @(negedge Clk);
    chk("len0_done_clear", int'(clr_done), 0);

    // Render hogging the port against a waiting coll request.
    do_reset();
    got = 1'b0; prev_rg = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      if (k > 1) chk("starve_rv", int'(render_valid), int'(prev_rg));
      render_req = 1'b1; render_addr = 19'd1; coll_req = !got; coll_addr = 19'd2;
      exp_g = GUARD && (k == LIMIT + 1);
      #1 chk("starve_cgnt", int'(coll_gnt), int'(exp_g));
      chk("starve_stall", int'(render_stall), int'(exp_g));
      prev_rg = !exp_g;
      got = got | exp_g;
    end
    idle_inputs();

    // Randomized traffic against a memory-level model.
    do_reset();
    preload();
    cnt = 0; pend = 1'b0; exp_oob = 1'b0; have = 1'b0;
    e_rv = 1'b0; e_cv = 1'b0; e_d = '0;
    for (int n = 0; n < 600; n++) begin
      @(negedge Clk);
      if (have) begin
        chk("rnd_rv", int'(render_valid), int'(e_rv));
        if (e_rv) chk("rnd_rdata", int'(render_data), int'(e_d));
        chk("rnd_cv", int'(coll_valid), int'(e_cv));
        if (e_cv) chk("rnd_cdata", int'(coll_data), int'(e_d));
        chk("rnd_oob", int'(oob_err), int'(exp_oob));
      end
      render_req = ($urandom_range(0, 1) == 1);
      render_addr = rand_addr();
      if (!pend) begin
        coll_req = ($urandom_range(0, 2) == 0);
        coll_addr = rand_addr();
      end
      wr_req = ($urandom_range(0, 1) == 1);
      wr_addr = rand_addr();
      wr_data = 5'($urandom);
      force_c = GUARD && (cnt >= LIMIT);
      g_r = render_req && !force_c;
      g_c = coll_req && (!render_req || force_c);
      ra = g_r ? int'(render_addr) : int'(coll_addr);
      wa = int'(wr_addr);
      if (ra >= DEPTH) d = '0;
      else if (wr_req && wa == ra) d = wr_data;
      else d = ref_mem[ra];
      #1 chk("rnd_cgnt", int'(coll_gnt), int'(g_c));
      chk("rnd_stall", int'(render_stall), int'(render_req && force_c));
      chk("rnd_wr_ready", int'(wr_ready), 1);
      if ((g_r || g_c) && ra >= DEPTH) exp_oob = 1'b1;
      if (wr_req && wa >= DEPTH) exp_oob = 1'b1;
      if (wr_req && wa < DEPTH) ref_mem[wa] = wr_data;
      cnt = g_c ? 0 : (coll_req ? cnt + 1 : cnt);
      pend = coll_req && !g_c;
      e_rv = g_r; e_cv = g_c; e_d = d; have = 1'b1;
    end
    @(negedge Clk);
    chk("rnd_rv_last", int'(render_valid), int'(e_rv));
    if (e_rv) chk("rnd_rdata_last", int'(render_data), int'(e_d));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
